// File: rtl/seq_multiplier_bcd_signed_if.sv
// -----------------------------------------------------------------------------
// seq_multiplier_bcd_signed_if
// Handshake and result bundle for the sequential signed/unsigned multiplier
// with binary-to-BCD conversion.
//
// Signals:
//   start        request a new operation (sampled on a rising clk edge)
//   signed_mode  1 = A/B are two's complement, 0 = unsigned (sampled with start)
//   A, B         N-bit operands (sampled with start)
//   busy         high while the multiplier is multiplying or converting
//   done         one-cycle pulse; results valid from this cycle on
//   bin_product  2N-bit product (two's complement in signed mode)
//   sign         product is negative (signed mode, nonzero product only)
//   bcd          NDIG-digit BCD magnitude, digit 0 in bits [3:0]
//   overflow     magnitude does not fit in NDIG digits
//
// Modports: master = operand source / display side, slave = multiplier.
// -----------------------------------------------------------------------------
interface seq_multiplier_bcd_signed_if #(
    parameter int N    = 8,
    parameter int NDIG = 5
) ();
    logic                start;
    logic                signed_mode;
    logic [N-1:0]        A;
    logic [N-1:0]        B;
    logic                busy;
    logic                done;
    logic [2*N-1:0]      bin_product;
    logic                sign;
    logic [4*NDIG-1:0]   bcd;
    logic                overflow;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done, bin_product, sign, bcd, overflow
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done, bin_product, sign, bcd, overflow
    );
endinterface

// File: rtl/seq_multiplier_bcd_signed.sv
// -----------------------------------------------------------------------------
// seq_multiplier_bcd_signed
// Sequential N x N multiplier (shift-add on operand magnitudes, N cycles)
// followed by an iterative double-dabble binary-to-BCD conversion (2N cycles).
// Supports unsigned and two's complement operands and flags BCD overflow when
// the product magnitude needs more than NDIG decimal digits.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    seq_multiplier_bcd_signed_if.slave (start/done handshake, operands,
//          binary product, sign, BCD digits, overflow)
//
// Latency: results and done are registered together at capture edge + 3N;
// done stays high for the following cycle only. Results hold until the next
// completion or reset.
// -----------------------------------------------------------------------------
module seq_multiplier_bcd_signed #(
    parameter int N    = 8,
    parameter int NDIG = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    seq_multiplier_bcd_signed_if.slave    bus
);

    localparam int PW = 2 * N;                  // product width
    localparam int DW = 4 * NDIG;               // BCD vector width
    localparam int CW = $clog2(PW) + 1;         // iteration counter width

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_CONV,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_neg;
    logic [PW-1:0]   r_mcand;      // shifted multiplicand magnitude
    logic [N-1:0]    r_mplier;     // multiplier magnitude, consumed LSB first
    logic [PW-1:0]   r_acc;        // partial product; holds |P| through CONV
    logic [PW-1:0]   r_bin;        // binary bits still to be shifted into BCD
    logic [DW-1:0]   r_digits;
    logic            r_ovf;        // sticky: a 1 left the top digit

    logic            r_busy;
    logic            r_done;
    logic [PW-1:0]   r_product;
    logic            r_sign;
    logic [DW-1:0]   r_bcd;
    logic            r_overflow;

    logic [N-1:0]    w_mag_a;
    logic [N-1:0]    w_mag_b;
    logic            w_neg;
    logic [PW-1:0]   w_acc_next;
    logic [DW-1:0]   w_adj;
    logic [DW-1:0]   w_digits_next;
    logic            w_ovf_next;
    logic [DW-1:0]   w_bcd_final;
    logic            w_neg_result;
    logic [PW-1:0]   w_product_final;

    // Magnitudes at capture. For the most negative value the N-bit negation
    // wraps back to 100..0, which read as unsigned is exactly 2^(N-1).
    assign w_mag_a = (bus.signed_mode && bus.A[N-1]) ? (~bus.A) + N'(1) : bus.A;
    assign w_mag_b = (bus.signed_mode && bus.B[N-1]) ? (~bus.B) + N'(1) : bus.B;
    assign w_neg   = bus.signed_mode & (bus.A[N-1] ^ bus.B[N-1]);

    assign w_acc_next = r_mplier[0] ? r_acc + r_mcand : r_acc;

    // Double-dabble correction: add 3 to every digit >= 5 before the shift.
    always_comb begin
        // NOTE: default assignment first so every path drives w_adj; without it
        // the conditional per-digit update would infer latches.
        w_adj = r_digits;
        for (int d = 0; d < NDIG; d++) begin
            if (r_digits[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_digits[4*d +: 4] + 4'd3;
            end
        end
    end

    // The corrected top bit is what leaves the highest digit on this shift.
    assign w_digits_next   = {w_adj[DW-2:0], r_bin[PW-1]};
    assign w_ovf_next      = r_ovf | w_adj[DW-1];
    assign w_bcd_final     = w_ovf_next ? {NDIG{4'h9}} : w_digits_next;
    assign w_neg_result    = r_neg & (|r_acc);
    assign w_product_final = w_neg_result ? (~r_acc) + PW'(1) : r_acc;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_neg      <= 1'b0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_bin      <= '0;
            r_digits   <= '0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_product  <= '0;
            r_sign     <= 1'b0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // DONE accepts a new start exactly like IDLE (back-to-back).
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state  <= S_MULT;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_neg    <= w_neg;
                        r_mcand  <= {{N{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_acc    <= '0;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end

                S_MULT: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (r_cnt == CW'(N - 1)) begin
                        r_state  <= S_CONV;
                        r_cnt    <= '0;
                        r_bin    <= w_acc_next;
                        r_digits <= '0;
                        r_ovf    <= 1'b0;
                    end else begin
                        r_cnt    <= r_cnt + CW'(1);
                    end
                end

                S_CONV: begin
                    r_bin    <= r_bin << 1;
                    r_digits <= w_digits_next;
                    r_ovf    <= w_ovf_next;
                    if (r_cnt == CW'(PW - 1)) begin
                        r_state    <= S_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_product  <= w_product_final;
                        r_sign     <= w_neg_result;
                        r_bcd      <= w_bcd_final;
                        r_overflow <= w_ovf_next;
                    end else begin
                        r_cnt      <= r_cnt + CW'(1);
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.bin_product = r_product;
    assign bus.sign        = r_sign;
    assign bus.bcd         = r_bcd;
    assign bus.overflow    = r_overflow;

endmodule

// File: tb/tb_seq_multiplier_bcd_signed.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier_bcd_signed
// Self-checking bench for seq_multiplier_bcd_signed. Three instances:
//   dut0  N=8, NDIG=5 (main instance)
//   dut1  N=8, NDIG=4 (shares dut0's inputs; exercises BCD overflow)
//   dut2  N=4, NDIG=2 (small instance)
// Expected results come from a plain-arithmetic model of signed/unsigned
// multiplication and decimal digit extraction.
// -----------------------------------------------------------------------------
module tb_seq_multiplier_bcd_signed;

    localparam int N0 = 8;
    localparam int D0 = 5;
    localparam int D1 = 4;
    localparam int N2 = 4;
    localparam int D2 = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    seq_multiplier_bcd_signed_if #(.N(N0), .NDIG(D0)) bus0 ();
    seq_multiplier_bcd_signed_if #(.N(N0), .NDIG(D1)) bus1 ();
    seq_multiplier_bcd_signed_if #(.N(N2), .NDIG(D2)) bus2 ();

    assign bus1.start       = bus0.start;
    assign bus1.signed_mode = bus0.signed_mode;
    assign bus1.A           = bus0.A;
    assign bus1.B           = bus0.B;

    seq_multiplier_bcd_signed #(.N(N0), .NDIG(D0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    seq_multiplier_bcd_signed #(.N(N0), .NDIG(D1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    seq_multiplier_bcd_signed #(.N(N2), .NDIG(D2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt0 = 0;
    int done_cnt2 = 0;
    int ops0 = 0;
    int ops2 = 0;
    logic [2*N0-1:0] prev_prod0 = '0;
    logic [4*D0-1:0] prev_bcd0  = '0;

    always @(negedge clk) begin
        if (bus0.done === 1'b1) done_cnt0++;
        if (bus2.done === 1'b1) done_cnt2++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: interpret operands, multiply as integers, then derive the
    // 2N-bit product, sign and decimal digits of the magnitude.
    function automatic void model(input int n, input int ndig, input bit sm,
                                  input longint a, input longint b,
                                  output longint prod, output bit sgn,
                                  output longint bcd, output bit ovf);
        longint one = 1;
        longint sa, sb, p, mag, lim;
        sa = (sm && a >= (one << (n - 1))) ? a - (one << n) : a;
        sb = (sm && b >= (one << (n - 1))) ? b - (one << n) : b;
        p    = sa * sb;
        mag  = (p < 0) ? -p : p;
        sgn  = (p < 0);
        prod = p & ((one << (2 * n)) - 1);
        lim  = 1;
        for (int i = 0; i < ndig; i++) lim = lim * 10;
        ovf = (mag >= lim);
        bcd = 0;
        for (int d = 0; d < ndig; d++) begin
            if (ovf) begin
                bcd = bcd | (longint'(9) << (4 * d));
            end else begin
                bcd = bcd | ((mag % 10) << (4 * d));
                mag = mag / 10;
            end
        end
    endfunction

    // One operation on dut0/dut1. With disturb set, the inputs are scrambled
    // and start is pulsed while busy; the result must be unaffected.
    task automatic op_main(input logic [7:0] a, input logic [7:0] b, input bit sm, input bit disturb);
        longint ep, eb5, eb4, ep1;
        bit     es, eo5, es1, eo4;
        int     lat;
        model(N0, D0, sm, a, b, ep, es, eb5, eo5);
        model(N0, D1, sm, a, b, ep1, es1, eb4, eo4);
        @(negedge clk);
        bus0.A           = a;
        bus0.B           = b;
        bus0.signed_mode = sm;
        bus0.start       = 1'b1;
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        ops0++;
        check("busy_after_capture", bus0.busy, 1);
        lat = 0;
        do begin
            if (disturb && lat == 4) begin
                bus0.A           = 8'($urandom);
                bus0.B           = 8'($urandom);
                bus0.signed_mode = 1'($urandom);
                bus0.start       = 1'b1;
            end else begin
                bus0.start = 1'b0;
            end
            @(posedge clk);
            lat++;
            #1;
            if (lat == N0 + 3) begin
                check("hold_mid_op_prod", bus0.bin_product, prev_prod0);
                check("hold_mid_op_bcd", bus0.bcd, prev_bcd0);
            end
        end while (bus0.done !== 1'b1 && lat < 4 * N0);
        check("latency", lat, 3 * N0);
        check("done", bus0.done, 1);
        check("busy_at_done", bus0.busy, 0);
        check("prod", bus0.bin_product, ep);
        check("sign", bus0.sign, es);
        check("bcd", bus0.bcd, eb5);
        check("ovf", bus0.overflow, eo5);
        check("d4_prod", bus1.bin_product, ep1);
        check("d4_sign", bus1.sign, es1);
        check("d4_bcd", bus1.bcd, eb4);
        check("d4_ovf", bus1.overflow, eo4);
        prev_prod0 = ep[2*N0-1:0];
        prev_bcd0  = eb5[4*D0-1:0];
    endtask

    task automatic op_n4(input logic [3:0] a, input logic [3:0] b, input bit sm);
        longint ep, eb;
        bit     es, eo;
        int     lat;
        model(N2, D2, sm, a, b, ep, es, eb, eo);
        @(negedge clk);
        bus2.A           = a;
        bus2.B           = b;
        bus2.signed_mode = sm;
        bus2.start       = 1'b1;
        @(posedge clk);
        #1;
        bus2.start = 1'b0;
        ops2++;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (bus2.done !== 1'b1 && lat < 4 * N2);
        check("n4_latency", lat, 3 * N2);
        check("n4_prod", bus2.bin_product, ep);
        check("n4_sign", bus2.sign, es);
        check("n4_bcd", bus2.bcd, eb);
        check("n4_ovf", bus2.overflow, eo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_before;
        bus0.start = 1'b0; bus0.signed_mode = 1'b0; bus0.A = '0; bus0.B = '0;
        bus2.start = 1'b0; bus2.signed_mode = 1'b0; bus2.A = '0; bus2.B = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus0.busy, 0);
        check("rst_done", bus0.done, 0);
        check("rst_prod", bus0.bin_product, 0);
        check("rst_bcd", bus0.bcd, 0);
        check("rst_sign", bus0.sign, 0);
        check("rst_ovf", bus0.overflow, 0);
        @(negedge clk);
        reset = 1'b1;

        // Unsigned basics
        op_main(8'd12, 8'd11, 1'b0, 1'b0);
        op_main(8'd25, 8'd4, 1'b0, 1'b0);
        // Signed cases, including most-negative squared and zero product
        op_main(8'hF4, 8'd11, 1'b1, 1'b0);
        op_main(8'h80, 8'h80, 1'b1, 1'b0);
        op_main(8'h00, 8'hFB, 1'b1, 1'b0);
        // Largest unsigned product; overflows the 4-digit instance
        op_main(8'd255, 8'd255, 1'b0, 1'b0);

        // Results hold while idle
        repeat (5) @(negedge clk);
        check("hold_idle_prod", bus0.bin_product, prev_prod0);
        check("hold_idle_bcd", bus0.bcd, prev_bcd0);
        check("done_pulses_a", done_cnt0, ops0);

        // Inputs and start ignored while busy, then a back-to-back start
        op_main(8'd3, 8'd5, 1'b0, 1'b1);
        op_main(8'd7, 8'd6, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("done_pulses_b", done_cnt0, ops0);

        // Randomized operations with random gaps and random disturbance
        for (int i = 0; i < 20; i++) begin
            op_main(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
        check("done_pulses_c", done_cnt0, ops0);

        // Asynchronous reset in the middle of conversion
        @(negedge clk);
        bus0.A = 8'd100; bus0.B = 8'd3; bus0.signed_mode = 1'b0; bus0.start = 1'b1;
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        repeat (N0 + 4) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("arst_busy", bus0.busy, 0);
        check("arst_done", bus0.done, 0);
        check("arst_prod", bus0.bin_product, 0);
        check("arst_bcd", bus0.bcd, 0);
        check("arst_sign", bus0.sign, 0);
        check("arst_ovf", bus0.overflow, 0);
        done_before = done_cnt0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3 * N0 + 5) @(posedge clk);
        #1;
        check("no_done_after_reset", done_cnt0, done_before);
        check("idle_after_reset", bus0.busy, 0);
        prev_prod0 = '0;
        prev_bcd0  = '0;
        op_main(8'd9, 8'd9, 1'b0, 1'b0);

        // Small instance
        op_n4(4'd15, 4'd15, 1'b0);
        for (int i = 0; i < 10; i++) begin
            op_n4(4'($urandom), 4'($urandom), 1'($urandom));
        end
        @(negedge clk);
        @(negedge clk);
        check("n4_done_pulses", done_cnt2, ops2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_multiplier_bcd_signed.md
Name: seq_multiplier_bcd_signed

Overview:
Parametrised sequential multiplier with iterative binary-to-BCD conversion. It extends the fixed-width multiply-and-display path with:
- a start/done handshake,
- signed (two's complement) operand mode,
- a configurable BCD digit count with overflow detection.

It sits between the operand source (register or UI logic) and the 7-segment/BCD display drivers.

Parameters:
N, 8, operand width in bits (N >= 2)
NDIG, 5, number of BCD output digits (NDIG >= 1)

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  request a new operation; sampled on a rising clk edge
signed_mode  in  1  1 = A/B are two's complement; 0 = unsigned; sampled with start
A  in  N  multiplicand, sampled with start
B  in  N  multiplier, sampled with start
busy  out  1  high while in MULT or CONV
done  out  1  one-cycle pulse; results valid from this cycle on
bin_product  out  2N  product; two's complement when signed_mode was 1
sign  out  1  1 = product is negative (only in signed mode, and only for a nonzero product)
bcd  out  4*NDIG  BCD magnitude; digit 0 is in bits [3:0]
overflow  out  1  magnitude >= 10^NDIG

Behaviour:
- Reset (reset=0, asynchronous):
  - state -> IDLE.
  - busy, done, sign, overflow = 0; bin_product = 0; bcd = 0.
  - Takes effect immediately, including mid-MULT or mid-CONV. The in-flight operation is discarded and no done pulse is produced.
- FSM states: IDLE, MULT, CONV, DONE.
  - IDLE: start=1 at an edge -> capture inputs (see below) and go to MULT. Otherwise stay in IDLE.
  - MULT: N cycles of shift-add on the operand magnitudes (iteration counter 0..N-1), then go to CONV.
  - CONV: 2N double-dabble cycles on the 2N-bit magnitude into NDIG digits. Before each shift, add 3 to every digit >= 5. After the last cycle go to DONE.
  - DONE: done=1 for exactly one cycle. start=1 here is accepted exactly as in IDLE (back-to-back). Otherwise go to IDLE.
- Input capture:
  - At the capture edge, latch signed_mode and the magnitudes |A| and |B| (magnitudes are taken only if signed_mode=1).
  - Latch neg = sign(A) XOR sign(B).
  - A, B and signed_mode changes after the capture edge have no effect.
  - start while busy=1 is ignored (no queueing).
- Latency: capture edge E; bin_product, bcd, sign and overflow update together at edge E+3N, with done high in the cycle that follows. For N=8 that is 24 edges.
- Output hold: bin_product, bcd, sign and overflow hold their last results through IDLE and through the next MULT/CONV. They change only at the next DONE entry or on reset.
- Arithmetic:
  - Magnitude product P = |A|*|B|, 2N bits. It cannot overflow, including the signed case -2^(N-1) * -2^(N-1) = 2^(2N-2).
  - bin_product = (neg && P != 0) ? -P : P, taken mod 2^(2N).
  - sign = neg && (P != 0). A zero product always has sign 0.
- BCD overflow:
  - If any 1 bit is shifted out of the top digit during CONV, then overflow=1 and bcd is forced to all 9s.
  - Otherwise overflow=0 and bcd is the exact magnitude.
  - With defaults N=8, NDIG=5, overflow is never set.

Test Plan:
1. Unsigned, N=8, NDIG=5: A=12, B=11, pulse start -> done exactly 24 edges after capture; bin_product=132, bcd=0x00132, sign=0, overflow=0. Also A=25, B=4 -> 100, bcd=0x00100.
2. Signed: A=8'hF4 (-12), B=11 -> bin_product=16'hFF7C, sign=1, bcd=0x00132. A=8'h80, B=8'h80 -> 16384, sign=0, bcd=0x16384. A=0, B=8'hFB -> 0, sign=0, bcd=0.
3. Unsigned A=255, B=255 -> 65025, bcd=0x65025, overflow=0. Repeat with NDIG=4 -> overflow=1, bcd=0x9999, bin_product=65025.
4. Handshake:
   - Start A=3, B=5; during busy, toggle A/B/signed_mode and pulse start -> result is still 15, with exactly one done pulse.
   - Assert start in the DONE cycle with A=7, B=6 -> second done 24 edges later, result 42.
   - Results hold between operations.
5. Reset: drive reset=0 asynchronously mid-CONV (between edges) -> busy/done/bin_product/bcd/sign/overflow go to 0 before the next edge; no done pulse follows. After reset=1, start A=9, B=9 -> 81.
6. N=4, NDIG=2 instance, unsigned A=15, B=15 -> 225, overflow=1, bcd=0x99; done 12 edges after capture.
